// File: rtl/vga_pkg.sv
// vga_pkg -- shared constants and types for the VGA controller.
//   CNT_W        : width of the horizontal/vertical counters and pixel coordinates
//   DEF_*        : default 640x480@60 timing (pixels for H, lines for V)
//   rgb_t        : packed 24-bit colour, r in the top byte
package vga_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_HDISP  = 640;
  localparam int DEF_HFP    = 16;
  localparam int DEF_HPULSE = 96;
  localparam int DEF_HBP    = 48;
  localparam int DEF_VDISP  = 480;
  localparam int DEF_VFP    = 10;
  localparam int DEF_VPULSE = 2;
  localparam int DEF_VBP    = 33;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

endpackage

// File: rtl/vga_sync_gen.sv
// vga_sync_gen -- horizontal/vertical position counters and raw timing decode.
//   clk, reset : clock and synchronous active-high reset
//   tick       : pixel-rate enable; counters advance only when it is high
//   hcnt, vcnt : current column / line position within the full frame
//   active     : position lies inside the visible area
//   hs_n, vs_n : undelayed active-low sync levels for the current position
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int HDISP  = DEF_HDISP,
  parameter int HFP    = DEF_HFP,
  parameter int HPULSE = DEF_HPULSE,
  parameter int HBP    = DEF_HBP,
  parameter int VDISP  = DEF_VDISP,
  parameter int VFP    = DEF_VFP,
  parameter int VPULSE = DEF_VPULSE,
  parameter int VBP    = DEF_VBP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt,
  output logic             active,
  output logic             hs_n,
  output logic             vs_n
);

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(HDISP + HFP + HPULSE + HBP - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(VDISP + VFP + VPULSE + VBP - 1);
  localparam logic [CNT_W-1:0] H_VIS   = CNT_W'(HDISP);
  localparam logic [CNT_W-1:0] V_VIS   = CNT_W'(VDISP);
  localparam logic [CNT_W-1:0] H_SYNC0 = CNT_W'(HDISP + HFP);
  localparam logic [CNT_W-1:0] H_SYNC1 = CNT_W'(HDISP + HFP + HPULSE - 1);
  localparam logic [CNT_W-1:0] V_SYNC0 = CNT_W'(VDISP + VFP);
  localparam logic [CNT_W-1:0] V_SYNC1 = CNT_W'(VDISP + VFP + VPULSE - 1);

  logic [CNT_W-1:0] hcnt_reg;
  logic [CNT_W-1:0] vcnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt_reg <= '0;
      vcnt_reg <= '0;
    end else if (tick) begin
      if (hcnt_reg == H_LAST) begin
        hcnt_reg <= '0;
        // Lines advance only when the column counter wraps.
        vcnt_reg <= (vcnt_reg == V_LAST) ? '0 : vcnt_reg + 1'b1;
      end else begin
        hcnt_reg <= hcnt_reg + 1'b1;
      end
    end
  end

  assign hcnt   = hcnt_reg;
  assign vcnt   = vcnt_reg;
  assign active = (hcnt_reg < H_VIS) && (vcnt_reg < V_VIS);
  assign hs_n   = !((hcnt_reg >= H_SYNC0) && (hcnt_reg <= H_SYNC1));
  assign vs_n   = !((vcnt_reg >= V_SYNC0) && (vcnt_reg <= V_SYNC1));

endmodule

// File: rtl/vga_controller.sv
// vga_controller -- VGA timing generator with a pull-style pixel source interface.
//   clk, reset          : system clock (pixel rate is clk/2), synchronous active-high reset
//   pix_req             : one-clk strobe requesting the colour of (pix_x, pix_y)
//   pix_x, pix_y        : requested coordinate, held until the next request
//   pix_r/g/b           : colour from the source, sampled on the pixel tick after pix_req
//   frame_start         : accompanies the request for pixel (0,0)
//   vga_clk             : DAC clock, rises mid-pixel while DAC data is stable
//   vga_hs, vga_vs      : active-low syncs, aligned with the colour they belong to
//   vga_blank_n         : high only for visible pixels
//   vga_sync_n          : sync-on-green disabled (constant 0)
//   vga_r/g/b           : DAC colour, zero while blanked
module vga_controller
  import vga_pkg::*;
#(
  parameter int HDISP  = DEF_HDISP,
  parameter int HFP    = DEF_HFP,
  parameter int HPULSE = DEF_HPULSE,
  parameter int HBP    = DEF_HBP,
  parameter int VDISP  = DEF_VDISP,
  parameter int VFP    = DEF_VFP,
  parameter int VPULSE = DEF_VPULSE,
  parameter int VBP    = DEF_VBP
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pix_req,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  input  logic [7:0] pix_r,
  input  logic [7:0] pix_g,
  input  logic [7:0] pix_b,
  output logic       frame_start,
  output logic       vga_clk,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b
);

  logic             ph_reg;
  logic             vga_clk_reg;
  logic             tick;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] vcnt;
  logic             active;
  logic             hs_n;
  logic             vs_n;

  // Request stage: what was asked for on the last tick.
  logic             req_reg;
  logic             frame_start_reg;
  logic [CNT_W-1:0] pix_x_reg;
  logic [CNT_W-1:0] pix_y_reg;
  logic             act_d_reg;
  logic             hs_d_reg;
  logic             vs_d_reg;

  // Output stage: DAC-facing registers, all updated on the same tick.
  logic             hs_reg;
  logic             vs_reg;
  logic             blank_n_reg;
  rgb_t             rgb_reg;
  rgb_t             src_rgb;

  assign tick    = ph_reg;
  assign src_rgb = {pix_r, pix_g, pix_b};

  vga_sync_gen #(
    .HDISP (HDISP),  .HFP (HFP),  .HPULSE (HPULSE),  .HBP (HBP),
    .VDISP (VDISP),  .VFP (VFP),  .VPULSE (VPULSE),  .VBP (VBP)
  ) u_sync_gen (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick),
    .hcnt   (hcnt),
    .vcnt   (vcnt),
    .active (active),
    .hs_n   (hs_n),
    .vs_n   (vs_n)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ph_reg          <= 1'b0;
      vga_clk_reg     <= 1'b0;
      req_reg         <= 1'b0;
      frame_start_reg <= 1'b0;
      pix_x_reg       <= '0;
      pix_y_reg       <= '0;
      act_d_reg       <= 1'b0;
      hs_d_reg        <= 1'b1;
      vs_d_reg        <= 1'b1;
      hs_reg          <= 1'b1;
      vs_reg          <= 1'b1;
      blank_n_reg     <= 1'b0;
      rgb_reg         <= '0;
    end else begin
      ph_reg      <= ~ph_reg;
      // Separate copy of the phase so the DAC clock has its own flop.
      vga_clk_reg <= ~ph_reg;

      // Strobes last exactly one clk because tick is never high twice in a row.
      req_reg         <= tick && active;
      frame_start_reg <= tick && active && (hcnt == '0) && (vcnt == '0);

      if (tick) begin
        act_d_reg <= active;
        hs_d_reg  <= hs_n;
        vs_d_reg  <= vs_n;
        if (active) begin
          pix_x_reg <= hcnt;
          pix_y_reg <= vcnt;
        end

        // The source answered the previous request during the clk before
        // this tick; sync/blank ride along from the request stage so all
        // DAC signals describe the same pixel.
        hs_reg      <= hs_d_reg;
        vs_reg      <= vs_d_reg;
        blank_n_reg <= act_d_reg;
        rgb_reg     <= act_d_reg ? src_rgb : '0;
      end
    end
  end

  assign pix_req     = req_reg;
  assign frame_start = frame_start_reg;
  assign pix_x       = pix_x_reg;
  assign pix_y       = pix_y_reg;
  assign vga_clk     = vga_clk_reg;
  assign vga_hs      = hs_reg;
  assign vga_vs      = vs_reg;
  assign vga_blank_n = blank_n_reg;
  assign vga_sync_n  = 1'b0;
  assign vga_r       = rgb_reg.r;
  assign vga_g       = rgb_reg.g;
  assign vga_b       = rgb_reg.b;

endmodule

// File: tb/tb_vga_controller.sv
// tb_vga_controller -- self-checking bench for vga_controller using a reduced
// timing set so that many full frames fit in a short run. Expected outputs are
// derived from the cycle count since reset release with plain arithmetic.
module tb_vga_controller;

  localparam int HDISP  = 16;
  localparam int HFP    = 4;
  localparam int HPULSE = 6;
  localparam int HBP    = 4;
  localparam int VDISP  = 8;
  localparam int VFP    = 2;
  localparam int VPULSE = 2;
  localparam int VBP    = 3;
  localparam int HT     = HDISP + HFP + HPULSE + HBP;   // 30 pixels per line
  localparam int VT     = VDISP + VFP + VPULSE + VBP;   // 15 lines per frame
  localparam int FRAME_CLK = 2 * HT * VT;               // 900 clk

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pix_req;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic [7:0] pix_r = 8'hFF;
  logic [7:0] pix_g = 8'hFF;
  logic [7:0] pix_b = 8'hFF;
  logic       frame_start;
  logic       vga_clk;
  logic       vga_hs;
  logic       vga_vs;
  logic       vga_blank_n;
  logic       vga_sync_n;
  logic [7:0] vga_r;
  logic [7:0] vga_g;
  logic [7:0] vga_b;

  int tests = 0;
  int fails = 0;
  int c = 0;          // clk edges since the last reset edge
  bit started = 0;
  int frames = 0;

  typedef struct packed {
    logic       req;
    logic       fs;
    logic [9:0] x;
    logic [9:0] y;
    logic       vclk;
    logic       hs;
    logic       vs;
    logic       bn;
    logic       sn;
    logic [23:0] rgb;
  } obs_t;

  vga_controller #(
    .HDISP (HDISP), .HFP (HFP), .HPULSE (HPULSE), .HBP (HBP),
    .VDISP (VDISP), .VFP (VFP), .VPULSE (VPULSE), .VBP (VBP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pix_req     (pix_req),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_r       (pix_r),
    .pix_g       (pix_g),
    .pix_b       (pix_b),
    .frame_start (frame_start),
    .vga_clk     (vga_clk),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_blank_n (vga_blank_n),
    .vga_sync_n  (vga_sync_n),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b)
  );

  always #10 clk = ~clk;

  // Expected outputs k clk after reset. Pixel p is ticked at k=2p+1, requested
  // during k=2p+2 and displayed from k=2p+4.
  function automatic obs_t model(input int k);
    obs_t e;
    int p, q, h, v;
    e    = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    e.vclk = (k % 2) == 1;
    if (k >= 2) begin
      p = k / 2 - 1;
      h = p % HT;
      v = (p / HT) % VT;
      e.req = (k % 2 == 0) && (h < HDISP) && (v < VDISP);
      e.fs  = (k % 2 == 0) && (h == 0) && (v == 0);
      // Coordinates hold the most recent visible pixel requested.
      if (v < VDISP) begin
        e.y = 10'(v);
        e.x = (h < HDISP) ? 10'(h) : 10'(HDISP - 1);
      end else begin
        e.x = 10'(HDISP - 1);
        e.y = 10'(VDISP - 1);
      end
    end
    q = k / 2 - 2;
    if (q >= 0) begin
      h = q % HT;
      v = (q / HT) % VT;
      e.hs  = !((h >= HDISP + HFP) && (h < HDISP + HFP + HPULSE));
      e.vs  = !((v >= VDISP + VFP) && (v < VDISP + VFP + VPULSE));
      e.bn  = (h < HDISP) && (v < VDISP);
      e.rgb = e.bn ? {8'(h), 8'(v), 8'hA5} : 24'h0;
    end
    return e;
  endfunction

  task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at c=%0d: got %h, required %h", name, c, act, exp);
    end
  endtask

  // Cycle counter mirrors the DUT's view of reset at each edge.
  initial forever begin
    @(posedge clk);
    if (reset) begin
      c = 0;
      started = 1;
    end else begin
      c = c + 1;
    end
  end

  // Pixel source: answers exactly one clk after the request and drives 8'hFF
  // at every other time, so late or early sampling shows up as FF.
  initial begin : source
    bit pend;
    logic [23:0] saved;
    pend = 0;
    saved = '0;
    forever begin
      @(posedge clk);
      #1;
      if (pend) {pix_r, pix_g, pix_b} = saved;
      else      {pix_r, pix_g, pix_b} = 24'hFFFFFF;
      pend  = pix_req;
      saved = {pix_x[7:0], pix_y[7:0], 8'hA5};
    end
  end

  // Per-cycle comparison against the model, plus literal pins.
  initial begin : compare
    obs_t act;
    obs_t exp;
    int shown;
    shown = 0;
    forever begin
      @(negedge clk);
      if (started) begin
        act = {pix_req, frame_start, pix_x, pix_y, vga_clk, vga_hs, vga_vs,
               vga_blank_n, vga_sync_n, vga_r, vga_g, vga_b};
        exp = model(c);
        tests++;
        if (act !== exp) begin
          fails++;
          if (shown < 20)
            $display("FAIL cycle c=%0d t=%0t: got req=%b fs=%b x=%0d y=%0d clk=%b hs=%b vs=%b bn=%b sn=%b rgb=%h, required req=%b fs=%b x=%0d y=%0d clk=%b hs=%b vs=%b bn=%b sn=%b rgb=%h",
                     c, $time, act.req, act.fs, act.x, act.y, act.vclk, act.hs, act.vs, act.bn, act.sn, act.rgb,
                     exp.req, exp.fs, exp.x, exp.y, exp.vclk, exp.hs, exp.vs, exp.bn, exp.sn, exp.rgb);
          shown++;
        end
        if (!reset) begin
          case (c)
            2:   pin("first_req_fs", {30'd0, pix_req, frame_start}, 32'h3);
            4:   pin("pix00_rgb", {7'd0, vga_blank_n, vga_r, vga_g, vga_b}, {7'd0, 1'b1, 24'h0000A5});
            6:   pin("pix10_rgb", {8'd0, vga_r, vga_g, vga_b}, 32'h0100A5);
            43:  pin("hs_before_fall", {31'd0, vga_hs}, 32'd1);
            44:  pin("hs_fall", {31'd0, vga_hs}, 32'd0);
            603: pin("vs_before_fall", {31'd0, vga_vs}, 32'd1);
            604: pin("vs_fall", {31'd0, vga_vs}, 32'd0);
            default: ;
          endcase
        end
      end
    end
  end

  // Whole-frame statistics between consecutive frame_start strobes.
  initial begin : stats
    bit win_ok;
    int per, reqs, hs_lo, vs_lo;
    win_ok = 0;
    per = 0; reqs = 0; hs_lo = 0; vs_lo = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        win_ok = 0;
      end else begin
        if (frame_start) begin
          if (win_ok) begin
            frames++;
            $display("[TB] frame %0d: period=%0d reqs=%0d hs_low=%0d vs_low=%0d", frames, per, reqs, hs_lo, vs_lo);
            pin("frame_period", per, FRAME_CLK);
            pin("reqs_per_frame", reqs, HDISP * VDISP);
            pin("hs_low_per_frame", hs_lo, VT * HPULSE * 2);
            pin("vs_low_per_frame", vs_lo, VPULSE * HT * 2);
          end
          win_ok = 1;
          per = 0; reqs = 0; hs_lo = 0; vs_lo = 0;
        end
        per++;
        if (pix_req) reqs++;
        if (!vga_hs) hs_lo++;
        if (!vga_vs) vs_lo++;
      end
    end
  end

  initial begin : main
    int n;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3 * FRAME_CLK + 10) @(posedge clk);

    // Mid-frame reset while pixel (10,5) is being requested.
    n = 0;
    #1;
    while (!(pix_req && pix_x == 10'd10 && pix_y == 10'd5) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests++;
    if (n >= 2000) begin
      fails++;
      $display("FAIL wait_req_10_5: timeout after 2000 clk waiting for request (10,5)");
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2 * FRAME_CLK + 10) @(posedge clk);

    // Random resets at random points with random lengths.
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(1, 1200)) @(posedge clk);
      #1 reset = 1'b1;
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1 reset = 1'b0;
    end
    repeat (2 * FRAME_CLK + 20) @(posedge clk);

    pin("full_frames_seen_ge4", {31'd0, frames >= 4}, 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_controller.md
VGA_CONTROLLER -- requirements
Module: vga_controller

Interface
REQ-001 SHALL have parameter HDISP, 640, visible pixels per line.
REQ-002 SHALL have parameter HFP, 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter HPULSE, 96, hsync pulse width in pixels.
REQ-004 SHALL have parameter HBP, 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter VDISP, 480, visible lines per frame.
REQ-006 SHALL have parameter VFP, 10, vertical front porch in lines.
REQ-007 SHALL have parameter VPULSE, 2, vsync pulse width in lines.
REQ-008 SHALL have parameter VBP, 33, vertical back porch in lines.
REQ-009 SHALL have port clk, input, 1, 50 MHz system clock; the only clock.
REQ-010 SHALL have port reset, input, 1, reset, synchronous and active-high.
REQ-011 SHALL have port pix_req, output, 1, one-clk strobe requesting the pixel at (pix_x, pix_y).
REQ-012 SHALL have port pix_x, output, 10, requested column, 0..HDISP-1.
REQ-013 SHALL have port pix_y, output, 10, requested row, 0..VDISP-1.
REQ-014 SHALL have ports pix_r, pix_g, pix_b, input, 8 each, pixel colour returned by the source.
REQ-015 SHALL have port frame_start, output, 1, one-clk strobe at the request for pixel (0,0).
REQ-016 SHALL have ports vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n, output, 1 each, DAC clock, syncs, blanking and sync-on-green.
REQ-017 SHALL have ports vga_r, vga_g, vga_b, output, 8 each, DAC colour.

Function
REQ-018 SHALL toggle an internal phase bit ph every clk; a pixel tick is a clk cycle with ph=1 (25 MHz pixel rate).
REQ-019 SHALL drive vga_clk from a register equal to ph, so vga_clk rises mid-pixel while DAC data is stable.
REQ-020 SHALL advance hcnt on each pixel tick, 0..HDISP+HFP+HPULSE+HBP-1 (0..799), wrapping to 0.
REQ-021 SHALL advance vcnt only on a tick where hcnt wraps, 0..VDISP+VFP+VPULSE+VBP-1 (0..524), wrapping to 0.
REQ-022 SHALL, on the clk following a tick where hcnt<HDISP and vcnt<VDISP, assert pix_req for exactly one clk with pix_x=hcnt, pix_y=vcnt; pix_x/pix_y hold until the next request.
REQ-023 SHALL sample pix_r/g/b on the next pixel tick after pix_req (source has 2 clk to respond; no back-pressure).
REQ-024 SHALL register vga_hs, vga_vs, vga_blank_n and vga_r/g/b together on that tick, so colour and sync for a pixel appear one pixel period after its request.
REQ-025 SHALL drive vga_hs low (active) for hcnt in [HDISP+HFP, HDISP+HFP+HPULSE-1] = [656,751], delayed identically to colour.
REQ-026 SHALL drive vga_vs low for vcnt in [VDISP+VFP, VDISP+VFP+VPULSE-1] = [490,491], delayed identically.
REQ-027 SHALL drive vga_blank_n=1 only for visible pixels and force vga_r/g/b to 0 when blanked, regardless of pix_r/g/b.
REQ-028 SHALL hold vga_sync_n at 0 permanently.
REQ-029 SHALL assert frame_start in the same clk as pix_req for (0,0) only.

Reset
REQ-030 SHALL, while reset=1 at a clk edge, clear ph, hcnt and vcnt to 0.
REQ-031 SHALL reset outputs to: vga_clk=0, vga_hs=1, vga_vs=1, vga_blank_n=0, vga_sync_n=0, vga_r/g/b=0, pix_req=0, frame_start=0, pix_x=0, pix_y=0.
REQ-032 SHALL, after reset deasserts (including mid-frame), restart at hcnt=vcnt=0, so the first pix_req is for (0,0) with frame_start, with no partial line emitted.

Structure
REQ-033 SHALL place the default timing constants and an rgb_t struct (r, g, b, 8 bits each) in shared package vga_pkg.
REQ-034 SHALL implement the hcnt/vcnt counters and raw sync/active decode in one sub-module, vga_sync_gen; vga_controller adds the pixel pipeline and output registers.

Verification
REQ-035 SHALL check: release reset -> pix_req for (0,0) with frame_start within 4 clk; next (0,0) request exactly 840000 clk later.
REQ-036 SHALL check: line period 1600 clk; vga_hs low exactly 192 clk per line; first hs fall 2 clk after the tick where hcnt=656.
REQ-037 SHALL check: vga_vs low exactly 2 lines (3200 clk) per frame, during vcnt 490-491.
REQ-038 SHALL check: source returns rgb = {x[7:0], y[7:0], 8'hA5} -> each visible pixel shows those values one pixel period after its request; blanked pixels show 0 with the source driving 8'hFF.
REQ-039 SHALL check: reset asserted at (x=300, y=200) for 3 clk -> reset values on all outputs, then the frame restarts at (0,0).
REQ-040 SHALL check: exactly 307200 pix_req strobes per frame; vga_sync_n is never 1.
